// File: rtl/clear_seq_pkg.sv
// Shared constants, state encoding and helpers for the clear/release sequencer.
package clear_seq_pkg;

  localparam int unsigned DefSyncStages  = 2;
  localparam int unsigned DefHoldCycles  = 4;
  localparam int unsigned DefPulseCycles = 3;
  localparam int unsigned DefCntW        = 8;

  typedef logic [1:0] state_t;

  localparam state_t StAssert = 2'd0;
  localparam state_t StHold   = 2'd1;
  localparam state_t StIdle   = 2'd2;
  localparam state_t StSwclr  = 2'd3;

  function automatic int unsigned cnt_width(int unsigned hold, int unsigned pulse);
    int unsigned m;
    m = (hold > pulse) ? hold : pulse;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Saturates at 2^w-1; callers keep w <= 32.
  function automatic logic [31:0] sat_inc(logic [31:0] v, int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/clear_seq_sync.sv
// N-stage synchronizer for reset release; cleared asynchronously, shifts in 1.
module clear_seq_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(1);
    end
  end

  assign rst_sync = sync_q[STAGES-1];

endmodule

// File: rtl/clear_release_sequencer.sv
// Async-assert / sync-release clear generator with software clear pulses.
// Optional event counter enabled by defining CLEAR_SEQ_EVENT_CNT_EN.
module clear_release_sequencer
  import clear_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DefSyncStages,
  parameter int unsigned HOLD_CYCLES  = DefHoldCycles,
  parameter int unsigned PULSE_CYCLES = DefPulseCycles,
  parameter int unsigned CNT_W        = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_req,
  output logic             clear,
  output logic             clear_busy,
  output logic             release_pulse,
  output logic [CNT_W-1:0] event_cnt
);

  if (SYNC_STAGES < 2) begin : g_err_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_err_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (PULSE_CYCLES < 1) begin : g_err_pulse
    $error("PULSE_CYCLES must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_err_cntw
    $error("CNT_W must be in 1..32");
  end

  localparam int unsigned CntW = cnt_width(HOLD_CYCLES, PULSE_CYCLES);
  localparam bit HoldOne = (HOLD_CYCLES == 1);
  // The ASSERT->HOLD edge is itself the first hold edge, hence the -2.
  localparam logic [CntW-1:0] HoldLoad  = (HOLD_CYCLES > 1) ? CntW'(HOLD_CYCLES - 2) : '0;
  localparam logic [CntW-1:0] PulseLoad = (PULSE_CYCLES > 0) ? CntW'(PULSE_CYCLES - 1) : '0;

  logic            rst_sync;
  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clear_q;
  logic            rel_q, rel_d;

  clear_seq_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst_sync(rst_sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = 1'b0;
    unique case (state_q)
      StAssert: begin
        if (rst_sync) begin
          if (HoldOne) begin
            state_d = StIdle;
            rel_d   = 1'b1;
          end else begin
            state_d = StHold;
            cnt_d   = HoldLoad;
          end
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StIdle: begin
        if (clear_req) begin
          state_d = StSwclr;
          cnt_d   = PulseLoad;
        end
      end
      StSwclr: begin
        // A fresh request restarts the pulse, taking priority over release.
        if (clear_req) begin
          cnt_d = PulseLoad;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StAssert;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      clear_q <= 1'b1;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clear_q <= (state_d != StIdle);
      rel_q   <= rel_d;
    end
  end

  assign clear         = clear_q;
  assign clear_busy    = clear_q;
  assign release_pulse = rel_q;

`ifdef CLEAR_SEQ_EVENT_CNT_EN
  logic [CNT_W-1:0] evt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else if (rel_q) begin
      evt_q <= CNT_W'(sat_inc(32'(evt_q), CNT_W));
    end
  end

  assign event_cnt = evt_q;
`else
  assign event_cnt = '0;
`endif

endmodule

// File: tb/tb_clear_release_sequencer.sv
// Self-checking bench: directed vector table, hand sequences, random vs. reference model.
module tb_clear_release_sequencer;

  localparam int SyncN  = 2;
  localparam int HoldN  = 4;
  localparam int PulseN = 3;
`ifdef CLEAR_SEQ_EVENT_CNT_EN
  localparam bit EvtEn = 1'b1;
`else
  localparam bit EvtEn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       clear_req;
  logic       clear, clear_busy, release_pulse;
  logic [7:0] event_cnt;
  logic       clear_s, busy_s, rel_s;
  logic [1:0] evt_s;

  clear_release_sequencer u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_req    (clear_req),
    .clear        (clear),
    .clear_busy   (clear_busy),
    .release_pulse(release_pulse),
    .event_cnt    (event_cnt)
  );

  clear_release_sequencer #(
    .CNT_W(2)
  ) u_dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_req    (clear_req),
    .clear        (clear_s),
    .clear_busy   (busy_s),
    .release_pulse(rel_s),
    .event_cnt    (evt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit rst_first;
    bit req;
    bit clr;
    bit rel;
    int evt;
  } vec_t;
  vec_t vecs[$];

  // Reference model: boot edge count, then "edges remaining" for software pulses.
  bit m_booting;
  int m_boot;
  bit m_clear;
  bit m_rel;
  int m_rem;
  int m_evt;
  int m_evt_sat;

  function automatic void model_reset();
    m_booting = 1'b1;
    m_boot    = 0;
    m_clear   = 1'b1;
    m_rel     = 1'b0;
    m_rem     = 0;
    m_evt     = 0;
    m_evt_sat = 0;
  endfunction

  function automatic void model_edge();
    bit prev_rel;
    if (!rst_n) return;
    prev_rel = m_rel;
    m_rel    = 1'b0;
    if (prev_rel) begin
      if (m_evt < 255) m_evt++;
      if (m_evt_sat < 3) m_evt_sat++;
    end
    if (m_booting) begin
      m_boot++;
      if (m_boot == SyncN + HoldN) begin
        m_booting = 1'b0;
        m_clear   = 1'b0;
        m_rel     = 1'b1;
      end
    end else if (!m_clear) begin
      if (clear_req) begin
        m_clear = 1'b1;
        m_rem   = PulseN;
      end
    end else begin
      if (clear_req) m_rem = PulseN;
      else m_rem--;
      if (m_rem == 0) begin
        m_clear = 1'b0;
        m_rel   = 1'b1;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: actual %0d required %0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    clear_req = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, " clear"}, 32'(clear), 32'(m_clear));
    check({tag, " busy"}, 32'(clear_busy), 32'(m_clear));
    check({tag, " rel"}, 32'(release_pulse), 32'(m_rel));
    check({tag, " evt"}, 32'(event_cnt), EvtEn ? 32'(m_evt) : 32'd0);
    check({tag, " evt_sat"}, 32'(evt_s), EvtEn ? 32'(m_evt_sat) : 32'd0);
  endtask

  function automatic void add(bit r, bit q, bit c, bit p, int e);
    vec_t v;
    v = '{rst_first: r, req: q, clr: c, rel: p, evt: e};
    vecs.push_back(v);
  endfunction

  initial begin
    rst_n     = 1'b1;
    clear_req = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("reset clear", 32'(clear), 32'd1);
    check("reset busy", 32'(clear_busy), 32'd1);
    check("reset rel", 32'(release_pulse), 32'd0);
    check("reset evt", 32'(event_cnt), 32'd0);

    // A: power-on, then one-cycle software request at edge 10.
    add(1, 0, 1, 0, 0);
    for (int i = 2; i <= 5; i++) add(0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0);
    for (int i = 7; i <= 9; i++) add(0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 1);
    add(0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 2);
    // B: request held through ASSERT/HOLD and the release edge is ignored.
    add(1, 1, 1, 0, 0);
    for (int i = 2; i <= 5; i++) add(0, 1, 1, 0, 0);
    add(0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1);
    // C: request held edges 10..12 extends the pulse to edge 15.
    add(1, 0, 1, 0, 0);
    for (int i = 2; i <= 5; i++) add(0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0);
    for (int i = 7; i <= 9; i++) add(0, 0, 0, 0, 1);
    for (int i = 10; i <= 12; i++) add(0, 1, 1, 0, 1);
    add(0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 2);

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) apply_reset();
      clear_req = vecs[i].req;
      step();
      check($sformatf("vec%0d clear", i), 32'(clear), 32'(vecs[i].clr));
      check($sformatf("vec%0d busy", i), 32'(clear_busy), 32'(vecs[i].clr));
      check($sformatf("vec%0d rel", i), 32'(release_pulse), 32'(vecs[i].rel));
      check($sformatf("vec%0d evt", i), 32'(event_cnt), EvtEn ? 32'(vecs[i].evt) : 32'd0);
    end

    // Reset glitch in the middle of a software pulse.
    apply_reset();
    repeat (9) step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    step();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("glitch clear hold", 32'(clear), 32'd1);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      check($sformatf("reboot e%0d clear", e), 32'(clear), (e < 6) ? 32'd1 : 32'd0);
      check($sformatf("reboot e%0d rel", e), 32'(release_pulse), (e == 6) ? 32'd1 : 32'd0);
    end
    check("reboot evt", 32'(event_cnt), EvtEn ? 32'd1 : 32'd0);

    // Saturation: boot release plus five software clears.
    apply_reset();
    repeat (6) step();
    for (int p = 0; p < 5; p++) begin
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      repeat (4) step();
    end
    check("sat evt_w8", 32'(event_cnt), EvtEn ? 32'd6 : 32'd0);
    check("sat evt_w2", 32'(evt_s), EvtEn ? 32'd3 : 32'd0);

    // Random traffic with occasional reset glitches and multi-cycle resets.
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      int r;
      clear_req = ($urandom_range(0, 3) == 0);
      step();
      compare_model($sformatf("rand%0d", c));
      r = $urandom_range(0, 99);
      if (r == 0) begin
        rst_n = 1'b0;
        model_reset();
        #2;
        check("rand glitch clear", 32'(clear), 32'd1);
        check("rand glitch rel", 32'(release_pulse), 32'd0);
        rst_n = 1'b1;
      end else if (r == 1) begin
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
